// File: rtl/alu_issue_arbiter_if.sv
// Request / ALU / response bundle between the lane requesters, the shared ALU
// and the issue arbiter. Per-requester fields are flattened, slice i = requester i.
interface alu_issue_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int PC_W    = 8,
   parameter int OP_W    = 5,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*OP_W-1:0]   req_op;
   logic [NUM_REQ*DATA_W-1:0] req_op1;
   logic [NUM_REQ*DATA_W-1:0] req_op2;
   logic [NUM_REQ*DATA_W-1:0] req_imm;
   logic [NUM_REQ*PC_W-1:0]   req_pc;

   logic                      alu_enable;
   logic [OP_W-1:0]           alu_instruction;
   logic [DATA_W-1:0]         alu_op1;
   logic [DATA_W-1:0]         alu_op2;
   logic [DATA_W-1:0]         alu_imm;
   logic [PC_W-1:0]           alu_pc;
   logic [DATA_W-1:0]         alu_result;

   logic                      resp_valid;
   logic [ID_W-1:0]           resp_id;
   logic [DATA_W-1:0]         resp_data;
   logic                      resp_ready;

   // master: requesters, ALU and response consumer
   modport master (
      output req_valid, req_op, req_op1, req_op2, req_imm, req_pc,
      output alu_result, resp_ready,
      input  req_ready, alu_enable, alu_instruction, alu_op1, alu_op2, alu_imm, alu_pc,
      input  resp_valid, resp_id, resp_data
   );

   modport slave (
      input  req_valid, req_op, req_op1, req_op2, req_imm, req_pc,
      input  alu_result, resp_ready,
      output req_ready, alu_enable, alu_instruction, alu_op1, alu_op2, alu_imm, alu_pc,
      output resp_valid, resp_id, resp_data
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one registered single-cycle ALU,
// with one op in flight and the result routed back by tag.

module alu_issue_lane #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 8,
   parameter int OP_W   = 5
) (
   input  logic              sel,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   input  logic [DATA_W-1:0] imm,
   input  logic [PC_W-1:0]   pc,
   output logic [OP_W-1:0]   g_op,
   output logic [DATA_W-1:0] g_op1,
   output logic [DATA_W-1:0] g_op2,
   output logic [DATA_W-1:0] g_imm,
   output logic [PC_W-1:0]   g_pc
);
   assign g_op  = sel ? op  : '0;
   assign g_op1 = sel ? op1 : '0;
   assign g_op2 = sel ? op2 : '0;
   assign g_imm = sel ? imm : '0;
   assign g_pc  = sel ? pc  : '0;
endmodule

module alu_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int PC_W    = 8,
   parameter int OP_W    = 5,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_issue_arbiter_if.slave   bus,
   output logic [31:0]          issue_count,
   output logic [31:0]          stall_count
);
   typedef enum logic {IDLE, INFLIGHT} state_t;

   state_t              state;
   logic [ID_W-1:0]     tag;
   logic [ID_W-1:0]     rr_ptr;
   logic                rst_done;

   logic                inflight, resp_hs, can_issue, accept, found;
   logic [ID_W-1:0]     win, nxt;
   logic [NUM_REQ-1:0]  grant;

   logic [NUM_REQ-1:0][OP_W-1:0]   lane_op;
   logic [NUM_REQ-1:0][DATA_W-1:0] lane_op1, lane_op2, lane_imm;
   logic [NUM_REQ-1:0][PC_W-1:0]   lane_pc;

   assign inflight  = (state == INFLIGHT);
   assign resp_hs   = inflight && bus.resp_ready;
   // rst_done holds off grants until the first edge after reset release
   assign can_issue = rst_done && (!inflight || resp_hs);

   always_comb begin
      logic [ID_W-1:0] cand;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign accept = can_issue && found;
   assign grant  = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
   assign nxt    = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      alu_issue_lane #(.DATA_W(DATA_W), .PC_W(PC_W), .OP_W(OP_W)) u_lane (
         .sel   (grant[i]),
         .op    (bus.req_op [i*OP_W   +: OP_W]),
         .op1   (bus.req_op1[i*DATA_W +: DATA_W]),
         .op2   (bus.req_op2[i*DATA_W +: DATA_W]),
         .imm   (bus.req_imm[i*DATA_W +: DATA_W]),
         .pc    (bus.req_pc [i*PC_W   +: PC_W]),
         .g_op  (lane_op[i]),
         .g_op1 (lane_op1[i]),
         .g_op2 (lane_op2[i]),
         .g_imm (lane_imm[i]),
         .g_pc  (lane_pc[i])
      );
   end

   // grant is one-hot or zero, so an OR of the gated lanes is the winner's slice
   always_comb begin
      bus.alu_instruction = '0;
      bus.alu_op1         = '0;
      bus.alu_op2         = '0;
      bus.alu_imm         = '0;
      bus.alu_pc          = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.alu_instruction = bus.alu_instruction | lane_op[i];
         bus.alu_op1         = bus.alu_op1 | lane_op1[i];
         bus.alu_op2         = bus.alu_op2 | lane_op2[i];
         bus.alu_imm         = bus.alu_imm | lane_imm[i];
         bus.alu_pc          = bus.alu_pc  | lane_pc[i];
      end
   end

   assign bus.req_ready  = grant;
   assign bus.alu_enable = accept;
   assign bus.resp_valid = inflight;
   assign bus.resp_id    = tag;
   assign bus.resp_data  = bus.alu_result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         tag         <= '0;
         rr_ptr      <= '0;
         rst_done    <= 1'b0;
         issue_count <= '0;
         stall_count <= '0;
      end else begin
         rst_done <= 1'b1;
         if (accept) begin
            state       <= INFLIGHT;
            tag         <= win;
            rr_ptr      <= nxt;
            issue_count <= issue_count + 32'd1;
         end else if (resp_hs) begin
            state <= IDLE;
         end
         if (|bus.req_valid && !accept)
            stall_count <= stall_count + 32'd1;
      end
   end
endmodule
